wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of entries in the slow-source writeback queue (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the clock; reset rst, synchronous, active-high; clock clk.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset, synchronous and active-high.
REQ-004 The block SHALL have port pipe_we, input, 1 bit, the single-cycle pipeline writeback request, always accepted.
REQ-005 The block SHALL have port pipe_waddr, input, 5 bits, the pipeline destination register.
REQ-006 The block SHALL have port pipe_wdata, input, 32 bits, the pipeline result.
REQ-007 The block SHALL have port lsu_valid, input, 1 bit, the slow-source (load/div) writeback offer.
REQ-008 The block SHALL have port lsu_ready, output, 1 bit, meaning the slow-source offer is accepted this cycle.
REQ-009 The block SHALL have port lsu_waddr, input, 5 bits, the slow-source destination register.
REQ-010 The block SHALL have port lsu_wdata, input, 32 bits, the slow-source result.
REQ-011 The block SHALL have port we, output, 1 bit, the register-file write enable (active-high).
REQ-012 The block SHALL have port waddr, output, 5 bits, the register-file write address.
REQ-013 The block SHALL have port wdata, output, 32 bits, the register-file write data.
REQ-014 The block SHALL have ports raddr1 and raddr2, each an input of 5 bits, the decode-stage read addresses being checked.
REQ-015 The block SHALL have ports pend_hit1 and pend_hit2, each an output of 1 bit, meaning a live queued write targets raddr1 or raddr2 respectively.
REQ-016 The block SHALL have port q_cnt, output, log2(DEPTH)+1 bits, the current queue occupancy.

Function
REQ-017 The we, waddr and wdata outputs SHALL be registered: a pipeline request in cycle N SHALL appear on we/waddr/wdata in cycle N+1.
REQ-018 A slow-source handshake is the cycle in which lsu_valid and lsu_ready are both 1; in that cycle the entry SHALL be pushed to the queue tail and marked live.
REQ-019 lsu_ready SHALL equal "queue not full"; a push SHALL NOT pass through a full queue, even when a pop occurs in the same cycle.
REQ-020 The pipeline SHALL have fixed priority: when pipe_we=1 with a nonzero address, the queue head SHALL NOT be written that cycle.
REQ-021 When no pipeline write is granted and the queue head is live, the head SHALL be popped and written in the next cycle, giving a minimum slow-source latency of 2 cycles from handshake to we.
REQ-022 A pipe_we with pipe_waddr=0 SHALL be treated as no request: we stays 0 and the queue head may pop.
REQ-023 An accepted lsu entry with lsu_waddr=0 SHALL be discarded and not enqueued.
REQ-024 WAW kill: a granted pipeline write SHALL clear the live bit of every queued entry with a matching address, so the queued write is treated as older and superseded.
REQ-025 An entry pushed in the same cycle as a matching pipeline write SHALL be treated as younger and SHALL NOT be killed.
REQ-026 A dead head SHALL be popped in any cycle, including cycles with a pipeline grant, without asserting we; at most one pop SHALL occur per cycle.
REQ-027 pend_hit1 and pend_hit2 SHALL be combinational, covering only live queue entries and excluding the output register; a read address of 0 SHALL always give 0.
REQ-028 Queue pointers SHALL wrap modulo DEPTH, and q_cnt SHALL count both live and dead entries.
REQ-029 When we=0, waddr and wdata SHALL hold 0.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL set we=0, waddr=0, wdata=0, empty the queue (q_cnt=0, all entries dead), and drive lsu_ready=1 in the following cycle.
REQ-031 Reset SHALL discard in-flight queued writes mid-operation; no write SHALL issue in the cycle after reset.

Structure
REQ-032 The shared defines include SHALL hold RegAddrBus, RegBus, ZeroWord, WriteEnable/WriteDisable, RstEnable, and the new constants WbQDepth=4 and WbQPtrW=2.
REQ-033 The queue SHALL be a single sub-module, wb_queue, with push/pop, a per-entry live bit, an address-match kill port and two address-match query ports; the arbitration logic SHALL remain in wb_arbiter.

Verification
REQ-034 Scenario: pipe_we=1, pipe_waddr=5, pipe_wdata=0xDEADBEEF in cycle 0 -> we=1, waddr=5, wdata=0xDEADBEEF in cycle 1 only.
REQ-035 Scenario: lsu push (addr 7, data 0x11) in cycle 0 while pipe_we=1 (addr 3) in cycles 1-2 -> writes addr 3 in cycles 2-3, then addr 7 with data 0x11 in cycle 4; pend_hit1=1 for raddr1=7 during cycles 1-3.
REQ-036 Scenario: 4 lsu pushes with pipe_we held at 1 -> lsu_ready=0 and q_cnt=4; the 5th offer is held and accepted only after the first pop.
REQ-037 Scenario: queue holds addr 9 and a pipeline write to addr 9 occurs -> the queued entry never produces we, pend_hit for 9 drops to 0 the next cycle, and q_cnt decrements once the entry is popped.
REQ-038 Scenario: lsu push with addr 0, and pipe_we with addr 0 -> no write, q_cnt unchanged.
REQ-039 Scenario: rst asserted with 3 entries queued -> q_cnt=0 and we=0 the next cycle, and none of the queued data is ever written.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared register-file writeback definitions used by the arbiter and its queue.
package wb_arbiter_pkg;

   typedef logic [4:0]  RegAddrBus;
   typedef logic [31:0] RegBus;

   localparam RegBus ZeroWord     = 32'h0000_0000;
   localparam logic  WriteEnable  = 1'b1;
   localparam logic  WriteDisable = 1'b0;
   localparam logic  RstEnable    = 1'b1;

   // Slow-source writeback queue geometry (depth is derived from pointer width).
   localparam int WbQPtrW  = 2;
   localparam int WbQDepth = 1 << WbQPtrW;

endpackage

// File: rtl/wb_arbiter_queue.sv
// Slow-source writeback FIFO with a per-entry live bit, an address-match kill
// port (WAW supersede) and two address-match query ports for decode hazards.
module wb_queue
   import wb_arbiter_pkg::*;
#(
   parameter  int DEPTH = WbQDepth,
   localparam int PW    = $clog2(DEPTH)
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_push,
   input  RegAddrBus       i_push_addr,
   input  RegBus           i_push_data,
   input  logic            i_pop,
   output logic            o_head_live,
   output RegAddrBus       o_head_addr,
   output RegBus           o_head_data,
   output logic            o_full,
   output logic            o_empty,
   output logic [PW:0]     o_cnt,
   input  logic            i_kill_en,
   input  RegAddrBus       i_kill_addr,
   input  RegAddrBus       i_q1_addr,
   output logic            o_q1_hit,
   input  RegAddrBus       i_q2_addr,
   output logic            o_q2_hit
);

   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [PW:0]      r_cnt;
   logic [DEPTH-1:0] r_live;
   RegAddrBus        r_addr [DEPTH];
   RegBus            r_data [DEPTH];

   logic [DEPTH-1:0] w_m1;
   logic [DEPTH-1:0] w_m2;

   // Per-entry query matches; only live entries can report a pending write.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_m1[gi] = r_live[gi] && (r_addr[gi] == i_q1_addr);
      assign w_m2[gi] = r_live[gi] && (r_addr[gi] == i_q2_addr);
   end

   assign o_q1_hit    = (i_q1_addr != 5'd0) && (|w_m1);
   assign o_q2_hit    = (i_q2_addr != 5'd0) && (|w_m2);
   assign o_full      = r_cnt[PW];
   assign o_empty     = (r_cnt == '0);
   assign o_cnt       = r_cnt;
   assign o_head_live = r_live[r_head];
   assign o_head_addr = r_addr[r_head];
   assign o_head_data = r_data[r_head];

   // Pointers and occupancy; wrap is implicit because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Live bits: a push into a slot wins over a same-cycle kill (the new entry
   // is younger than the pipeline write); pops and kills clear the bit.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_live <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_push && (r_tail == PW'(i)))
               r_live[i] <= 1'b1;
            else if ((i_pop && (r_head == PW'(i))) ||
                     (i_kill_en && (r_addr[i] == i_kill_addr)))
               r_live[i] <= 1'b0;
         end
      end
   end

   // Payload storage; contents of unoccupied slots are don't-care.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_addr[r_tail] <= i_push_addr;
         r_data[r_tail] <= i_push_data;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the single-cycle pipeline always wins, the
// slow (load/div) source is buffered in wb_queue and drained in idle slots.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter  int DEPTH = WbQDepth,
   localparam int PW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_we,
   input  logic [4:0]    pipe_waddr,
   input  logic [31:0]   pipe_wdata,
   input  logic          lsu_valid,
   output logic          lsu_ready,
   input  logic [4:0]    lsu_waddr,
   input  logic [31:0]   lsu_wdata,
   output logic          we,
   output logic [4:0]    waddr,
   output logic [31:0]   wdata,
   input  logic [4:0]    raddr1,
   input  logic [4:0]    raddr2,
   output logic          pend_hit1,
   output logic          pend_hit2,
   output logic [PW:0]   q_cnt
);

   logic      w_pipe_req;
   logic      w_push;
   logic      w_pop;
   logic      w_head_wr;
   logic      w_full;
   logic      w_empty;
   logic      w_head_live;
   RegAddrBus w_head_addr;
   RegBus     w_head_data;

   logic      r_we;
   RegAddrBus r_waddr;
   RegBus     r_wdata;

   // A write to r0 is architecturally a no-op, so it neither wins the port nor kills.
   assign w_pipe_req = pipe_we && (pipe_waddr != 5'd0);
   assign lsu_ready  = !w_full;
   assign w_push     = lsu_valid && lsu_ready && (lsu_waddr != 5'd0);
   // Dead heads drain unconditionally; live heads only when the pipeline is idle.
   assign w_pop      = !w_empty && (!w_head_live || !w_pipe_req);
   assign w_head_wr  = w_pop && w_head_live;

   wb_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_addr (lsu_waddr),
      .i_push_data (lsu_wdata),
      .i_pop       (w_pop),
      .o_head_live (w_head_live),
      .o_head_addr (w_head_addr),
      .o_head_data (w_head_data),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_cnt       (q_cnt),
      .i_kill_en   (w_pipe_req),
      .i_kill_addr (pipe_waddr),
      .i_q1_addr   (raddr1),
      .o_q1_hit    (pend_hit1),
      .i_q2_addr   (raddr2),
      .o_q2_hit    (pend_hit2)
   );

   // Registered write port; address and data are forced to zero on idle cycles.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_we    <= WriteDisable;
         r_waddr <= '0;
         r_wdata <= ZeroWord;
      end else if (w_pipe_req) begin
         r_we    <= WriteEnable;
         r_waddr <= pipe_waddr;
         r_wdata <= pipe_wdata;
      end else if (w_head_wr) begin
         r_we    <= WriteEnable;
         r_waddr <= w_head_addr;
         r_wdata <= w_head_data;
      end else begin
         r_we    <= WriteDisable;
         r_waddr <= '0;
         r_wdata <= ZeroWord;
      end
   end

   assign we    = r_we;
   assign waddr = r_waddr;
   assign wdata = r_wdata;

endmodule
